spi_master_param: RTL and testbench
===================================

Name: spi_master_param

Overview:
- Parametrised SPI master, the next generation of the current fixed 8-bit master.
- Generic word width, NUM_SS chip selects, and all four CPOL/CPH modes.
- Programmable SCK divider, with a start/busy/done handshake to the processor side.
- Sits between the processor register interface and the external SPI pins. All logic runs on clk_m; there is no derived clock domain.

Parameters:
- DATA_W, 8: bits per transfer word (2..32).
- DIV_W, 8: width of clk_div.
- NUM_SS, 1: number of slave-select lines (1..8).
- SEL_W, 1: width of ss_sel; must satisfy 2^SEL_W >= NUM_SS.

Ports:
- clk_m, input, 1: system clock; every flop is on its rising edge.
- rst, input, 1: synchronous reset, active-low.
- start, input, 1: one-cycle request to begin a transfer.
- CPOL, input, 1: SCK idle level.
- CPH, input, 1: clock phase. 0 = sample on the leading edge; 1 = sample on the trailing edge.
- clk_div, input, DIV_W: SCK half-period is clk_div+1 clk_m cycles.
- ss_sel, input, SEL_W: index of the SS line to assert.
- tx_data, input, DATA_W: word to transmit.
- rx_data, output, DATA_W: last received word; held until the next done.
- busy, output, 1: transfer in progress.
- done, output, 1: one-cycle pulse; rx_data is valid in that cycle.
- sel_err, output, 1: one-cycle pulse when start arrives with ss_sel >= NUM_SS.
- SS, output, NUM_SS: active-low slave selects.
- SCK, output, 1: SPI clock.
- MOSI, output, 1: serial data out.
- MISO, input, 1: serial data in.

Behaviour:
- Reset values (rst==0 at a clk_m edge): SS all 1, SCK=CPOL, MOSI=0, busy=0, done=0, sel_err=0, rx_data=0, state IDLE.
- Reset mid-transfer aborts the transfer immediately. No done pulse is produced.
- States: IDLE -> LEAD -> XFER -> TRAIL -> IDLE. H denotes the latched clk_div+1.
- IDLE:
  - SCK tracks the live CPOL; MOSI=0.
  - Accept start when busy=0 and ss_sel < NUM_SS. On accept, latch tx_data, CPOL, CPH, clk_div and ss_sel into shadow registers.
  - Inputs changing during a transfer have no effect.
- Start with ss_sel >= NUM_SS: no transfer, sel_err=1 for one cycle, state stays IDLE.
- Start while busy=1: ignored; no error is flagged.
- Timing, with start sampled at edge 0:
  - Edge 1: busy=1, SS[sel]=0, state LEAD. If CPH=0, MOSI = first tx bit at this edge.
  - Edge 1+H: first SCK toggle, state XFER.
  - SCK toggles every H cycles, 2*DATA_W toggles in total. The last toggle is at edge 1+2*DATA_W*H, returning SCK to CPOL; state goes to TRAIL.
  - Edge 1+(2*DATA_W+1)*H: SS all 1, busy=0, done=1, rx_data updated, MOSI=0, state IDLE.
- CPH=0:
  - MISO is sampled at each odd (leading) toggle.
  - MOSI advances at each even (trailing) toggle, except the final one.
- CPH=1:
  - MOSI advances at each odd (leading) toggle.
  - MISO is sampled at each even (trailing) toggle.
- Shift order is MSB first. Received bits enter the shift register LSB and move toward the MSB.
- Back-to-back transfers: a start in the done cycle is accepted. SS then returns low one cycle later, so SS is high for exactly 1 cycle between words.
- clk_div=0 gives H=1 and SCK = clk_m/2. clk_div = all-ones gives H = 2^DIV_W; the divider counter must not overflow at this value.
- Bit counter width is clog2(DATA_W)+1. There is no wrap inside a transfer.
- SCK, SS and MOSI are registered outputs with no combinational path from inputs. They are never driven to z.

Optional Feature:
- Macro: SPI_LSB_FIRST_EN.
- Defined:
  - Adds input port lsb_first (1 bit), latched at start.
  - lsb_first=1: transmit tx_data[0] first. Received bits enter at the MSB and shift toward bit 0, so rx_data bit order matches the wire order.
  - lsb_first=0: MSB first, as above.
- Undefined: the port is absent and transfers are always MSB first.

Test Plan:
- Mode 0 (CPOL=0, CPH=0), clk_div=0, DATA_W=8, tx=0xA5, slave returns 0x3C.
  - MOSI shows 1,0,1,0,0,1,0,1.
  - done at cycle 18 after start.
  - rx_data=0x3C; 16 SCK toggles; SS[0] low from cycle 1 to cycle 17.
- Modes 1, 2 and 3, clk_div=3, tx=0x81, slave returns 0x7E.
  - SCK idles at CPOL.
  - Sample/shift edges are as specified.
  - rx_data=0x7E; done at cycle 1+17*4=69.
- Start asserted during busy, with tx=0xFF, after a transfer of 0x12: ignored; the wire carries only 0x12 and only one done pulse occurs.
- Errors and back-to-back: NUM_SS=3, ss_sel=3 -> sel_err pulse, SS stays 3'b111, busy stays 0. ss_sel=2 with start in the done cycle -> SS=3'b011, SS[2] high for exactly 1 cycle between the two words.
- rst=0 asserted at cycle 9 of a mode-3 transfer -> next cycle: SS all 1, SCK=1, busy=0, MOSI=0, no done pulse; the following start runs normally.
- SPI_LSB_FIRST_EN defined, lsb_first=1, tx=0x01, slave sends bits 1,0,0,0,0,0,0,0 in wire order -> MOSI shows 1 first, then seven 0s; rx_data=0x01.

Source files
------------

// File: rtl/spi_master_param.sv
// Parametrised SPI master: DATA_W-bit words, NUM_SS selects, all CPOL/CPH modes, SCK half-period clk_div+1.
// Optional macro SPI_LSB_FIRST_EN adds the lsb_first port for LSB-first transfers.
module spi_master_param #(
  parameter int DATA_W = 8,
  parameter int DIV_W  = 8,
  parameter int NUM_SS = 1,
  parameter int SEL_W  = 1
) (
  input  logic              clk_m,
  input  logic              rst,
  input  logic              start,
  input  logic              CPOL,
  input  logic              CPH,
  input  logic [DIV_W-1:0]  clk_div,
  input  logic [SEL_W-1:0]  ss_sel,
  input  logic [DATA_W-1:0] tx_data,
`ifdef SPI_LSB_FIRST_EN
  input  logic              lsb_first,
`endif
  output logic [DATA_W-1:0] rx_data,
  output logic              busy,
  output logic              done,
  output logic              sel_err,
  output logic [NUM_SS-1:0] SS,
  output logic              SCK,
  output logic              MOSI,
  input  logic              MISO,
  output logic [1:0]        state_o
);

  localparam int BIT_W = $clog2(DATA_W) + 1;

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_LEAD  = 2'd1,
    S_XFER  = 2'd2,
    S_TRAIL = 2'd3
  } state_t;

  state_t             state_q, state_d;
  logic [DIV_W-1:0]   cnt_q, cnt_d;
  logic [DIV_W-1:0]   div_q, div_d;
  logic [BIT_W-1:0]   bit_q, bit_d;
  logic [DATA_W-1:0]  txs_q, txs_d;
  logic [DATA_W-1:0]  rxs_q, rxs_d;
  logic [DATA_W-1:0]  rx_q, rx_d;
  logic [NUM_SS-1:0]  ss_q, ss_d;
  logic               cpol_q, cpol_d;
  logic               cph_q, cph_d;
  logic               lsb_q, lsb_d;
  logic               sck_q, sck_d;
  logic               mosi_q, mosi_d;
  logic               busy_q, busy_d;
  logic               done_q, done_d;
  logic               err_q, err_d;

  logic lsb_in;
`ifdef SPI_LSB_FIRST_EN
  assign lsb_in = lsb_first;
`else
  assign lsb_in = 1'b0;
`endif

  // One SCK event every div_q+1 cycles; comparing against div_q keeps the counter in range.
  logic tick;
  logic last_bit;
  logic sel_ok;
  assign tick     = (cnt_q == div_q);
  assign last_bit = (bit_q == BIT_W'(DATA_W - 1));
  assign sel_ok   = (int'(ss_sel) < NUM_SS);

  function automatic logic out_bit(input logic [DATA_W-1:0] v, input logic lsb);
    return lsb ? v[0] : v[DATA_W-1];
  endfunction

  function automatic logic [DATA_W-1:0] tx_shift(input logic [DATA_W-1:0] v, input logic lsb);
    return lsb ? (v >> 1) : (v << 1);
  endfunction

  function automatic logic [DATA_W-1:0] rx_shift(input logic [DATA_W-1:0] v, input logic b,
                                                 input logic lsb);
    return lsb ? {b, v[DATA_W-1:1]} : {v[DATA_W-2:0], b};
  endfunction

  function automatic logic [NUM_SS-1:0] ss_decode(input logic [SEL_W-1:0] sel);
    logic [NUM_SS-1:0] v;
    v = '1;
    for (int i = 0; i < NUM_SS; i++) begin
      if (int'(sel) == i) v[i] = 1'b0;
    end
    return v;
  endfunction

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    div_d   = div_q;
    bit_d   = bit_q;
    txs_d   = txs_q;
    rxs_d   = rxs_q;
    rx_d    = rx_q;
    ss_d    = ss_q;
    cpol_d  = cpol_q;
    cph_d   = cph_q;
    lsb_d   = lsb_q;
    sck_d   = sck_q;
    mosi_d  = mosi_q;
    busy_d  = busy_q;
    done_d  = 1'b0;
    err_d   = 1'b0;

    case (state_q)
      S_IDLE: begin
        sck_d  = CPOL;
        mosi_d = 1'b0;
        busy_d = 1'b0;
        ss_d   = '1;
        if (start) begin
          if (sel_ok) begin
            state_d = S_LEAD;
            busy_d  = 1'b1;
            ss_d    = ss_decode(ss_sel);
            cpol_d  = CPOL;
            cph_d   = CPH;
            div_d   = clk_div;
            lsb_d   = lsb_in;
            cnt_d   = '0;
            bit_d   = '0;
            rxs_d   = '0;
            // CPH=0 presents the first bit before the first SCK edge.
            if (!CPH) begin
              mosi_d = out_bit(tx_data, lsb_in);
              txs_d  = tx_shift(tx_data, lsb_in);
            end else begin
              txs_d  = tx_data;
            end
          end else begin
            err_d = 1'b1;
          end
        end
      end

      S_LEAD, S_XFER: begin
        if (tick) begin
          cnt_d   = '0;
          sck_d   = ~sck_q;
          state_d = S_XFER;
          if (sck_q == cpol_q) begin
            // Leading edge: SCK leaves its idle level.
            if (cph_q) begin
              mosi_d = out_bit(txs_q, lsb_q);
              txs_d  = tx_shift(txs_q, lsb_q);
            end else begin
              rxs_d  = rx_shift(rxs_q, MISO, lsb_q);
            end
          end else begin
            bit_d = bit_q + BIT_W'(1);
            if (cph_q) begin
              rxs_d = rx_shift(rxs_q, MISO, lsb_q);
            end else if (!last_bit) begin
              mosi_d = out_bit(txs_q, lsb_q);
              txs_d  = tx_shift(txs_q, lsb_q);
            end
            if (last_bit) state_d = S_TRAIL;
          end
        end else begin
          cnt_d = cnt_q + DIV_W'(1);
        end
      end

      S_TRAIL: begin
        if (tick) begin
          cnt_d   = '0;
          state_d = S_IDLE;
          busy_d  = 1'b0;
          done_d  = 1'b1;
          ss_d    = '1;
          mosi_d  = 1'b0;
          rx_d    = rxs_q;
        end else begin
          cnt_d = cnt_q + DIV_W'(1);
        end
      end

      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clk_m) begin
    if (!rst) begin
      state_q <= S_IDLE;
      cnt_q   <= '0;
      div_q   <= '0;
      bit_q   <= '0;
      txs_q   <= '0;
      rxs_q   <= '0;
      rx_q    <= '0;
      ss_q    <= '1;
      cpol_q  <= 1'b0;
      cph_q   <= 1'b0;
      lsb_q   <= 1'b0;
      sck_q   <= CPOL;
      mosi_q  <= 1'b0;
      busy_q  <= 1'b0;
      done_q  <= 1'b0;
      err_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      div_q   <= div_d;
      bit_q   <= bit_d;
      txs_q   <= txs_d;
      rxs_q   <= rxs_d;
      rx_q    <= rx_d;
      ss_q    <= ss_d;
      cpol_q  <= cpol_d;
      cph_q   <= cph_d;
      lsb_q   <= lsb_d;
      sck_q   <= sck_d;
      mosi_q  <= mosi_d;
      busy_q  <= busy_d;
      done_q  <= done_d;
      err_q   <= err_d;
    end
  end

  assign rx_data = rx_q;
  assign busy    = busy_q;
  assign done    = done_q;
  assign sel_err = err_q;
  assign SS      = ss_q;
  assign SCK     = sck_q;
  assign MOSI    = mosi_q;
  assign state_o = state_q;

endmodule

// File: tb/tb_spi_master_param.sv
// Directed bench for spi_master_param (DATA_W=8, NUM_SS=3) with a behavioural SPI slave.
module tb_spi_master_param;

  logic       clk_m = 1'b0;
  logic       rst = 1'b0;
  logic       start = 1'b0;
  logic       CPOL = 1'b0;
  logic       CPH = 1'b0;
  logic [7:0] clk_div = 8'd0;
  logic [1:0] ss_sel = 2'd0;
  logic [7:0] tx_data = 8'd0;
  logic [7:0] rx_data;
  logic       busy, done, sel_err;
  logic [2:0] SS;
  logic       SCK, MOSI;
  logic       MISO = 1'b0;
  logic [1:0] state_o;
`ifdef SPI_LSB_FIRST_EN
  logic       lsb_first = 1'b0;
`endif

  spi_master_param #(.DATA_W(8), .DIV_W(8), .NUM_SS(3), .SEL_W(2)) dut (
    .clk_m(clk_m), .rst(rst), .start(start), .CPOL(CPOL), .CPH(CPH),
    .clk_div(clk_div), .ss_sel(ss_sel), .tx_data(tx_data),
`ifdef SPI_LSB_FIRST_EN
    .lsb_first(lsb_first),
`endif
    .rx_data(rx_data), .busy(busy), .done(done), .sel_err(sel_err),
    .SS(SS), .SCK(SCK), .MOSI(MOSI), .MISO(MISO), .state_o(state_o)
  );

  always #5 clk_m = ~clk_m;

  int n_cmp = 0;
  int n_err = 0;
  int done_cnt = 0;

  always @(posedge clk_m) if (done === 1'b1) done_cnt++;

  // Slave: word fixed when SS falls, MSB first on the wire, captures MOSI in wire order.
  logic [7:0] slv_word = 8'd0;
  logic       slv_cpol = 1'b0;
  logic       slv_cph = 1'b0;
  logic [7:0] slv_sh = 8'd0;
  logic [7:0] slv_rx = 8'd0;
  int         slv_tog = 0;
  logic       slv_act = 1'b0;
  logic       slv_sck = 1'b0;

  always @(SS or SCK) begin
    if (SS === 3'b111) begin
      slv_act = 1'b0;
    end else if (!slv_act) begin
      slv_act = 1'b1;
      slv_sck = SCK;
      slv_sh  = slv_word;
      slv_rx  = 8'd0;
      slv_tog = 0;
      if (!slv_cph) begin
        MISO   = slv_sh[7];
        slv_sh = slv_sh << 1;
      end
    end else if (SCK !== slv_sck) begin
      slv_sck = SCK;
      slv_tog++;
      if ((SCK != slv_cpol) ^ slv_cph) begin
        slv_rx = {slv_rx[6:0], MOSI};
      end else begin
        MISO   = slv_sh[7];
        slv_sh = slv_sh << 1;
      end
    end
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk_m);
    #1;
  endtask

  task automatic launch(input logic cpol, input logic cph, input logic [7:0] div,
                        input logic [1:0] sel, input logic [7:0] tx);
    CPOL = cpol; CPH = cph; clk_div = div; ss_sel = sel; tx_data = tx;
    start = 1'b1;
    tick();
    start = 1'b0;
  endtask

  task automatic wait_done(output int cyc, output int lowc);
    cyc  = 1;
    lowc = (SS !== 3'b111) ? 1 : 0;
    while (done !== 1'b1 && cyc < 6000) begin
      tick();
      cyc++;
      if (SS !== 3'b111) lowc++;
    end
  endtask

  initial begin
    int cyc, lowc, d0;
    logic mp, mh;

    // Reset state
    tick(); tick();
    chk("rst_ss", SS, 3'b111);
    chk("rst_sck", SCK, 1'b0);
    chk("rst_mosi", MOSI, 1'b0);
    chk("rst_busy", busy, 1'b0);
    chk("rst_done", done, 1'b0);
    chk("rst_selerr", sel_err, 1'b0);
    chk("rst_rx", rx_data, 8'h00);
    chk("rst_state", state_o, 2'd0);
    CPOL = 1'b1;
    tick();
    chk("rst_sck_cpol1", SCK, 1'b1);
    CPOL = 1'b0;
    rst = 1'b1;
    tick(); tick();

    // Mode 0, clk_div=0, tx A5, slave 3C
    slv_cpol = 1'b0; slv_cph = 1'b0; slv_word = 8'h3C;
    launch(1'b0, 1'b0, 8'd0, 2'd0, 8'hA5);
    chk("m0_busy", busy, 1'b1);
    chk("m0_ss", SS, 3'b110);
    chk("m0_first_mosi", MOSI, 1'b1);
    chk("m0_state_lead", state_o, 2'd1);
    wait_done(cyc, lowc);
    chk("m0_done_cycle", cyc, 18);
    chk("m0_ss_low_cycles", lowc, 17);
    chk("m0_rx", rx_data, 8'h3C);
    chk("m0_wire_mosi", slv_rx, 8'hA5);
    chk("m0_toggles", slv_tog, 16);
    chk("m0_done_ss", SS, 3'b111);
    chk("m0_done_busy", busy, 1'b0);
    chk("m0_done_mosi", MOSI, 1'b0);
    tick();
    chk("m0_done_pulse", done, 1'b0);

    // Modes 1..3, clk_div=3, tx 81, slave 7E
    for (int m = 1; m < 4; m++) begin
      mp = m[1]; mh = m[0];
      slv_cpol = mp; slv_cph = mh; slv_word = 8'h7E;
      CPOL = mp;
      tick(); tick();
      chk("mode_idle_sck", SCK, mp);
      launch(mp, mh, 8'd3, 2'd0, 8'h81);
      chk("mode_lead_sck", SCK, mp);
      chk("mode_lead_mosi", MOSI, mh ? 1'b0 : 1'b1);
      wait_done(cyc, lowc);
      chk("mode_done_cycle", cyc, 69);
      chk("mode_rx", rx_data, 8'h7E);
      chk("mode_wire_mosi", slv_rx, 8'h81);
      chk("mode_toggles", slv_tog, 16);
      chk("mode_done_sck", SCK, mp);
    end

    // Start during busy is ignored; only one done
    CPOL = 1'b0;
    slv_cpol = 1'b0; slv_cph = 1'b0; slv_word = 8'h55;
    tick(); tick();
    d0 = done_cnt;
    launch(1'b0, 1'b0, 8'd0, 2'd0, 8'h12);
    tick(); tick(); tick();
    tx_data = 8'hFF;
    start = 1'b1;
    tick();
    start = 1'b0;
    chk("busy_no_err", sel_err, 1'b0);
    wait_done(cyc, lowc);
    chk("busy_done_cycle", cyc, 14);
    chk("busy_wire_mosi", slv_rx, 8'h12);
    chk("busy_rx", rx_data, 8'h55);
    tick(); tick(); tick();
    chk("busy_one_done", done_cnt - d0, 1);
    chk("busy_idle_after", busy, 1'b0);

    // Invalid select
    launch(1'b0, 1'b0, 8'd0, 2'd3, 8'h33);
    chk("selerr_pulse", sel_err, 1'b1);
    chk("selerr_ss", SS, 3'b111);
    chk("selerr_busy", busy, 1'b0);
    chk("selerr_state", state_o, 2'd0);
    tick();
    chk("selerr_one_cycle", sel_err, 1'b0);
    chk("selerr_no_start", busy, 1'b0);

    // Back-to-back on SS[2]
    slv_word = 8'hC3;
    launch(1'b0, 1'b0, 8'd0, 2'd2, 8'h5A);
    chk("b2b_ss_first", SS, 3'b011);
    wait_done(cyc, lowc);
    chk("b2b_done_cycle1", cyc, 18);
    chk("b2b_done_ss_high", SS, 3'b111);
    chk("b2b_rx1", rx_data, 8'hC3);
    slv_word = 8'h69;
    launch(1'b0, 1'b0, 8'd0, 2'd2, 8'h96);
    chk("b2b_ss_second", SS, 3'b011);
    chk("b2b_busy_second", busy, 1'b1);
    wait_done(cyc, lowc);
    chk("b2b_done_cycle2", cyc, 18);
    chk("b2b_rx2", rx_data, 8'h69);
    chk("b2b_wire2", slv_rx, 8'h96);

    // Reset mid mode-3 transfer
    slv_cpol = 1'b1; slv_cph = 1'b1; slv_word = 8'hA5;
    CPOL = 1'b1;
    tick(); tick();
    launch(1'b1, 1'b1, 8'd3, 2'd0, 8'h3C);
    for (int i = 0; i < 8; i++) tick();
    chk("rstx_busy_before", busy, 1'b1);
    d0 = done_cnt;
    rst = 1'b0;
    tick();
    rst = 1'b1;
    chk("rstx_ss", SS, 3'b111);
    chk("rstx_sck", SCK, 1'b1);
    chk("rstx_busy", busy, 1'b0);
    chk("rstx_mosi", MOSI, 1'b0);
    chk("rstx_done", done, 1'b0);
    chk("rstx_state", state_o, 2'd0);
    for (int i = 0; i < 6; i++) tick();
    chk("rstx_no_done", done_cnt - d0, 0);
    launch(1'b1, 1'b1, 8'd3, 2'd0, 8'h3C);
    wait_done(cyc, lowc);
    chk("rstx_next_cycle", cyc, 69);
    chk("rstx_next_rx", rx_data, 8'hA5);
    chk("rstx_next_wire", slv_rx, 8'h3C);

    // Largest divider: H = 256
    CPOL = 1'b0;
    slv_cpol = 1'b0; slv_cph = 1'b0; slv_word = 8'h18;
    tick(); tick();
    launch(1'b0, 1'b0, 8'hFF, 2'd1, 8'hC3);
    chk("divmax_ss", SS, 3'b101);
    wait_done(cyc, lowc);
    chk("divmax_done_cycle", cyc, 4353);
    chk("divmax_rx", rx_data, 8'h18);
    chk("divmax_wire", slv_rx, 8'hC3);
    chk("divmax_toggles", slv_tog, 16);

`ifdef SPI_LSB_FIRST_EN
    // LSB first: wire carries tx[0] first, rx keeps wire order
    slv_word = 8'h80;
    lsb_first = 1'b1;
    launch(1'b0, 1'b0, 8'd0, 2'd0, 8'h01);
    lsb_first = 1'b0;
    chk("lsb_first_mosi", MOSI, 1'b1);
    wait_done(cyc, lowc);
    chk("lsb_done_cycle", cyc, 18);
    chk("lsb_rx", rx_data, 8'h01);
    chk("lsb_wire", slv_rx, 8'h80);
`endif

    tick();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
